// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmit engine among NUM_REQ
//   byte-stream requesters. A grant is held until the requester marks a byte
//   as the last of its packet, or until MAX_BURST bytes have been sent.
//   Only one byte is ever outstanding at the transmitter.
//
// Handshake: a byte moves from requester i when req_valid[i] and
//   req_ready[i] are both high at a rising edge of clk_fpga. req_ready does
//   not depend on req_valid, so a requester may hold its byte as long as it
//   likes; once req_valid is raised, the data and last flag must stay stable
//   until the transfer completes.
//
// Ports:
//   clk_fpga      in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   req_valid     in   [NUM_REQ]    byte available per requester
//   req_data      in   [8*NUM_REQ]  requester i byte on [8i+7:8i]
//   req_last      in   [NUM_REQ]    offered byte ends its packet
//   req_ready     out  [NUM_REQ]    byte accepted (combinational, one-hot/zero)
//   tx_data       out  [8]          byte to the transmitter (registered)
//   tx_start      out               one-cycle start pulse (registered)
//   tx_busy       in                transmitter busy
//   grant_id      out  [clog2(NUM_REQ)] current or last granted requester
//   grant_active  out               a grant is held
//   state_dbg     out  [2]          FSM state (0 IDLE, 1 SEND, 2 ACK, 3 DRAIN)

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 grant_active,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ACK   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [7:0]     burst_q, burst_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d;
  logic           last_flag_q, last_flag_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;
  logic           hs;

  // Search upward from the requester after last_grant, wrapping, so the
  // requester just served has the lowest priority in the next round.
  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Ready only in SEND with the transmitter idle; this keeps at most one
  // byte outstanding and delays acceptance while a frame is still running.
  always_comb begin : ready_gen
    req_ready = '0;
    if (state_q == S_SEND && !tx_busy) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign hs = (state_q == S_SEND) && req_valid[grant_q] && !tx_busy;

  always_comb begin : fsm_next
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    last_flag_d  = last_flag_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          burst_d = 8'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hs) begin
          tx_data_d   = req_data[{grant_q, 3'b000} +: 8];
          tx_start_d  = 1'b1;
          last_flag_d = req_last[grant_q];
          if (burst_q != 8'hFF) begin
            burst_d = burst_q + 8'd1;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if (last_flag_q || burst_q == 8'(MAX_BURST)) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga) begin : fsm_regs
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      burst_q      <= 8'd0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      last_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      last_flag_q  <= last_flag_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_id     = grant_q;
  assign grant_active = (state_q != S_IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
// Requesters are byte queues; a transmitter model raises tx_busy the cycle
// after each tx_start for busy_len cycles. Every tx_start is compared against
// an expected queue of {grant_id, byte}.

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk_fpga = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_fpga = ~clk_fpga;

  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last  = '0;
  logic [8*NR-1:0] req_data  = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            grant_active;
  logic [1:0]      state_dbg;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .state_dbg    (state_dbg)
  );

  // ---------------- transmitter model ----------------
  int   busy_len   = 10;
  int   busy_cnt   = 0;
  logic busy_force = 1'b0;

  always @(posedge clk_fpga) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || busy_force;

  // ---------------- check / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
    end
  endtask

  always @(negedge clk_fpga) begin
    logic [9:0] e;
    if (tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("tx_extra", 32'(tx_start), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {22'd0, grant_id, tx_data}, {22'd0, e});
      end
    end
    check("rdy_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (!grant_active) check("rdy_idle", 32'(req_ready), 32'd0);
  end

  // ---------------- requester driver ----------------
  logic [8:0]    rq[NR][$];
  logic [NR-1:0] hold  = '0;
  logic [NR-1:0] taken = '0;

  initial begin
    logic [8:0] ent;
    forever begin
      @(negedge clk_fpga);
      for (int i = 0; i < NR; i++) begin
        if (taken[i] && rq[i].size() > 0) ent = rq[i].pop_front();
      end
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() > 0 && !hold[i]) begin
          ent = rq[i][0];
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = ent[7:0];
          req_last[i]        = ent[8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      taken = reset ? '0 : (req_valid & req_ready);
    end
  end

  task automatic send(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_tx(input int r, input logic [7:0] d);
    exp_q.push_back({2'(r), d});
  endtask

  function automatic logic rq_empty();
    logic em = 1'b1;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) em = 1'b0;
    return em;
  endfunction

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk_fpga); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk_fpga);
    #2 reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_tx_start"},  32'(tx_start),     32'd0);
    check({t, "_tx_data"},   32'(tx_data),      32'd0);
    check({t, "_grant_id"},  32'(grant_id),     32'd0);
    check({t, "_grant_act"}, 32'(grant_active), 32'd0);
    check({t, "_req_ready"}, 32'(req_ready),    32'd0);
    check({t, "_state"},     32'(state_dbg),    32'd0);
  endtask

  task automatic wait_starts(input int n, input string t);
    int cyc = 0;
    while (n_starts < n && cyc < 500) begin @(negedge clk_fpga); cyc++; end
    check(t, 32'(n_starts), 32'(n));
  endtask

  task automatic wait_busy(input logic lvl, input string t);
    int cyc = 0;
    while (tx_busy !== lvl && cyc < 200) begin @(negedge clk_fpga); cyc++; end
    check(t, 32'(tx_busy), 32'(lvl));
  endtask

  task automatic wait_grant(input string t);
    int cyc = 0;
    while (!grant_active && cyc < 200) begin @(negedge clk_fpga); cyc++; end
    check(t, 32'(grant_active), 32'd1);
  endtask

  task automatic wait_done(input string t);
    int cyc = 0;
    while (!(exp_q.size() == 0 && !grant_active && !tx_busy && rq_empty()) && cyc < 3000) begin
      @(negedge clk_fpga); cyc++;
    end
    check({t, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({t, "_released"}, 32'(grant_active), 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;

    do_reset();
    @(negedge clk_fpga);
    check_reset_vals("rst0");

    // T1: single requester 1, three bytes, 10-cycle frames
    @(posedge clk_fpga); #2;
    busy_len = 10;
    base = n_starts;
    send(1, 8'hA5, 1'b0); send(1, 8'h3C, 1'b0); send(1, 8'h7E, 1'b1);
    expect_tx(1, 8'hA5); expect_tx(1, 8'h3C); expect_tx(1, 8'h7E);
    wait_starts(base + 3, "t1_starts");
    wait_busy(1'b1, "t1_busy_rise");
    wait_busy(1'b0, "t1_busy_fall");
    check("t1_still_granted", 32'(grant_active), 32'd1);
    check("t1_gid", 32'(grant_id), 32'd1);
    @(negedge clk_fpga);
    check("t1_release", 32'(grant_active), 32'd0);
    check("t1_gid_held", 32'(grant_id), 32'd1);
    wait_done("t1");

    // T2: requesters 0 and 2 together from reset, then again
    do_reset();
    #1 busy_len = 3;
    send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b1);
    send(2, 8'h21, 1'b0); send(2, 8'h22, 1'b1);
    expect_tx(0, 8'h01); expect_tx(0, 8'h02); expect_tx(2, 8'h21); expect_tx(2, 8'h22);
    wait_done("t2a");
    @(posedge clk_fpga); #2;
    send(2, 8'h23, 1'b0); send(2, 8'h24, 1'b1);
    send(0, 8'h03, 1'b0); send(0, 8'h04, 1'b1);
    expect_tx(0, 8'h03); expect_tx(0, 8'h04); expect_tx(2, 8'h23); expect_tx(2, 8'h24);
    wait_done("t2b");

    // T3: burst cap of 4 on a 6-byte packet from requester 3, requester 1 waiting
    @(posedge clk_fpga); #2;
    for (int k = 1; k <= 6; k++) send(3, 8'(8'h30 + k), (k == 6));
    send(1, 8'h11, 1'b0); send(1, 8'h12, 1'b1);
    for (int k = 1; k <= 4; k++) expect_tx(3, 8'(8'h30 + k));
    expect_tx(1, 8'h11); expect_tx(1, 8'h12);
    expect_tx(3, 8'h35); expect_tx(3, 8'h36);
    wait_done("t3");

    // T4: requester 0 pauses mid-packet; grant must stay, requester 1 waits
    @(posedge clk_fpga); #2;
    busy_len = 4;
    base = n_starts;
    send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b0); send(0, 8'h43, 1'b1);
    send(1, 8'h15, 1'b1);
    expect_tx(0, 8'h41); expect_tx(0, 8'h42); expect_tx(0, 8'h43); expect_tx(1, 8'h15);
    wait_starts(base + 1, "t4_first");
    @(posedge clk_fpga); #2;
    hold[0] = 1'b1;
    repeat (20) begin
      @(negedge clk_fpga);
      check("t4_no_start", 32'(tx_start), 32'd0);
      check("t4_no_rdy1", 32'(req_ready[1]), 32'd0);
      check("t4_gid", 32'(grant_id), 32'd0);
      check("t4_active", 32'(grant_active), 32'd1);
    end
    check("t4_paused", 32'(n_starts), 32'(base + 1));
    @(posedge clk_fpga); #2;
    hold[0] = 1'b0;
    wait_done("t4");

    // T5: reset during DRAIN of byte 2; arbitration restarts at requester 0
    @(posedge clk_fpga); #2;
    base = n_starts;
    send(2, 8'h51, 1'b0); send(2, 8'h52, 1'b0); send(2, 8'h53, 1'b1);
    expect_tx(2, 8'h51); expect_tx(2, 8'h52);
    wait_starts(base + 2, "t5_two");
    wait_busy(1'b1, "t5_busy");
    @(posedge clk_fpga); #2;
    check("t5_in_drain", 32'(state_dbg), 32'd3);
    reset = 1'b1;
    rq[2].delete();
    send(1, 8'h61, 1'b1); send(2, 8'h62, 1'b1); send(3, 8'h63, 1'b1);
    expect_tx(1, 8'h61); expect_tx(2, 8'h62); expect_tx(3, 8'h63);
    @(posedge clk_fpga); #2;
    reset = 1'b0;
    @(negedge clk_fpga);
    check_reset_vals("t5_rst");
    wait_done("t5");

    // T6: tx_busy already high on SEND entry holds off req_ready
    @(posedge clk_fpga); #2;
    busy_len = 3;
    busy_force = 1'b1;
    send(0, 8'h71, 1'b1);
    expect_tx(0, 8'h71);
    wait_grant("t6_grant");
    for (int k = 0; k < 5; k++) begin
      check("t6_rdy_low", 32'(req_ready), 32'd0);
      check("t6_send", 32'(state_dbg), 32'd1);
      if (k < 4) @(negedge clk_fpga);
    end
    @(posedge clk_fpga); #2;
    busy_force = 1'b0;
    @(negedge clk_fpga);
    check("t6_rdy_high", 32'(req_ready), 32'd1);
    @(negedge clk_fpga);
    check("t6_start", 32'(tx_start), 32'd1);
    wait_done("t6");

    // T7: all four valid, two 1-byte packets each: strict rotation
    @(posedge clk_fpga); #2;
    for (int i = 0; i < NR; i++) begin
      send(i, 8'(8'h80 + i), 1'b1);
      send(i, 8'(8'h90 + i), 1'b1);
    end
    expect_tx(1, 8'h81); expect_tx(2, 8'h82); expect_tx(3, 8'h83); expect_tx(0, 8'h80);
    expect_tx(1, 8'h91); expect_tx(2, 8'h92); expect_tx(3, 8'h93); expect_tx(0, 8'h90);
    wait_done("t7");

    repeat (3) @(negedge clk_fpga);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
